// File: rtl/hi_reader_seq.sv
// Exchange sequencer for the HF reader datapath: steps minor_mode through transmit,
// guard and tag-response reception, timed by the datapath's frame_tick boundary.
module hi_reader_seq #(
   parameter logic [3:0]  MODE_RX_AMP       = 4'd1,
   parameter logic [3:0]  MODE_SEND_FULL    = 4'd4,
   parameter logic [3:0]  MODE_SEND_SHALLOW = 4'd5,
   parameter logic [3:0]  MODE_SNIFF_AMP    = 4'd7,
   parameter int unsigned QUIET_FRAMES      = 3
) (
   input  logic        ck_1356meg,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        cmd_start,
   input  logic        cmd_abort,
   input  logic        cmd_full_mod,
   input  logic        sniff_en,
   input  logic [11:0] tx_frames,
   input  logic [7:0]  guard_frames,
   input  logic [11:0] rx_timeout,
   input  logic [13:0] amp_in,
   input  logic [13:0] amp_thresh,
   output logic [3:0]  minor_mode,
   output logic        busy,
   output logic        rx_active,
   output logic        tag_detect,
   output logic        timeout,
   output logic        done,
   output logic [11:0] rx_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TX,
      S_GUARD,
      S_RX_WAIT,
      S_RX_DATA
   } state_t;

   localparam logic [3:0] QUIET_LIMIT = 4'(QUIET_FRAMES);

   state_t      state, state_d;
   logic [11:0] frame_cnt, frame_cnt_d;
   logic [7:0]  guard_q, guard_d;
   logic [11:0] timeout_q, timeout_d;
   logic        full_q, full_d;
   logic [3:0]  quiet_cnt, quiet_d, quiet_inc;
   logic [11:0] rx_count_d;
   logic [3:0]  mode_d;
   logic        tag_d, tmo_d, done_d;
   logic        amp_present;

   assign amp_present = (amp_in >= amp_thresh);
   assign quiet_inc   = quiet_cnt + 4'd1;

   // frame_cnt counts down through TX and GUARD, and counts up as the wait counter in RX_WAIT.
   always_comb begin
      state_d     = state;
      frame_cnt_d = frame_cnt;
      guard_d     = guard_q;
      timeout_d   = timeout_q;
      full_d      = full_q;
      quiet_d     = quiet_cnt;
      rx_count_d  = rx_count;
      tag_d       = 1'b0;
      tmo_d       = 1'b0;
      done_d      = 1'b0;
      if (cmd_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (cmd_start) begin
                  guard_d    = guard_frames;
                  timeout_d  = rx_timeout;
                  full_d     = cmd_full_mod;
                  rx_count_d = 12'd0;
                  quiet_d    = 4'd0;
                  if (tx_frames != 12'd0) begin
                     state_d     = S_TX;
                     frame_cnt_d = tx_frames;
                  end else if (guard_frames != 8'd0) begin
                     state_d     = S_GUARD;
                     frame_cnt_d = {4'd0, guard_frames};
                  end else begin
                     state_d     = S_RX_WAIT;
                     frame_cnt_d = 12'd0;
                  end
               end
            end
            S_TX: begin
               if (frame_tick) begin
                  if (frame_cnt == 12'd1) begin
                     if (guard_q != 8'd0) begin
                        state_d     = S_GUARD;
                        frame_cnt_d = {4'd0, guard_q};
                     end else begin
                        state_d     = S_RX_WAIT;
                        frame_cnt_d = 12'd0;
                     end
                  end else begin
                     frame_cnt_d = frame_cnt - 12'd1;
                  end
               end
            end
            S_GUARD: begin
               if (frame_tick) begin
                  if (frame_cnt == 12'd1) begin
                     state_d     = S_RX_WAIT;
                     frame_cnt_d = 12'd0;
                  end else begin
                     frame_cnt_d = frame_cnt - 12'd1;
                  end
               end
            end
            S_RX_WAIT: begin
               // A present tag on the tick that would also expire the wait still counts as detection.
               if (frame_tick) begin
                  if (amp_present) begin
                     state_d    = S_RX_DATA;
                     tag_d      = 1'b1;
                     rx_count_d = 12'd1;
                     quiet_d    = 4'd0;
                  end else if (({1'b0, frame_cnt} + 13'd1) >= {1'b0, timeout_q}) begin
                     state_d = S_IDLE;
                     tmo_d   = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     frame_cnt_d = frame_cnt + 12'd1;
                  end
               end
            end
            S_RX_DATA: begin
               if (frame_tick) begin
                  rx_count_d = (rx_count == 12'hFFF) ? rx_count : rx_count + 12'd1;
                  if (amp_present) begin
                     quiet_d = 4'd0;
                  end else begin
                     quiet_d = quiet_inc;
                     if (quiet_inc == QUIET_LIMIT) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next state so none of them follows an input combinationally.
   always_comb begin
      mode_d = MODE_RX_AMP;
      case (state_d)
         S_IDLE:  mode_d = sniff_en ? MODE_SNIFF_AMP : MODE_RX_AMP;
         S_TX:    mode_d = full_d ? MODE_SEND_FULL : MODE_SEND_SHALLOW;
         default: mode_d = MODE_RX_AMP;
      endcase
   end

   always_ff @(negedge ck_1356meg or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         frame_cnt  <= 12'd0;
         guard_q    <= 8'd0;
         timeout_q  <= 12'd0;
         full_q     <= 1'b0;
         quiet_cnt  <= 4'd0;
         rx_count   <= 12'd0;
         minor_mode <= MODE_RX_AMP;
         busy       <= 1'b0;
         rx_active  <= 1'b0;
         tag_detect <= 1'b0;
         timeout    <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_d;
         frame_cnt  <= frame_cnt_d;
         guard_q    <= guard_d;
         timeout_q  <= timeout_d;
         full_q     <= full_d;
         quiet_cnt  <= quiet_d;
         rx_count   <= rx_count_d;
         minor_mode <= mode_d;
         busy       <= (state_d != S_IDLE);
         rx_active  <= (state_d == S_RX_WAIT) || (state_d == S_RX_DATA);
         tag_detect <= tag_d;
         timeout    <= tmo_d;
         done       <= done_d;
      end
   end

endmodule

// File: tb/tb_hi_reader_seq.sv
// Self-checking bench for hi_reader_seq: a frame-count model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_hi_reader_seq;

   logic        ck = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_tick = 1'b0;
   logic        cmd_start = 1'b0;
   logic        cmd_abort = 1'b0;
   logic        cmd_full_mod = 1'b0;
   logic        sniff_en = 1'b0;
   logic [11:0] tx_frames = 12'd0;
   logic [7:0]  guard_frames = 8'd0;
   logic [11:0] rx_timeout = 12'd0;
   logic [13:0] amp_in = 14'd0;
   logic [13:0] amp_thresh = 14'd0;
   logic [3:0]  minor_mode;
   logic        busy, rx_active, tag_detect, timeout, done;
   logic [11:0] rx_count;

   int n_vec = 0;
   int n_err = 0;
   bit check_en = 1'b0;

   hi_reader_seq dut (
      .ck_1356meg  (ck),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .cmd_start   (cmd_start),
      .cmd_abort   (cmd_abort),
      .cmd_full_mod(cmd_full_mod),
      .sniff_en    (sniff_en),
      .tx_frames   (tx_frames),
      .guard_frames(guard_frames),
      .rx_timeout  (rx_timeout),
      .amp_in      (amp_in),
      .amp_thresh  (amp_thresh),
      .minor_mode  (minor_mode),
      .busy        (busy),
      .rx_active   (rx_active),
      .tag_detect  (tag_detect),
      .timeout     (timeout),
      .done        (done),
      .rx_count    (rx_count)
   );

   always #5 ck = ~ck;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: an exchange is a count of frame ticks since start; TX covers ticks [0,tx),
   // GUARD covers [tx,tx+guard), and every later tick is a receive tick.
   bit       m_busy, m_det, m_full, m_tag, m_tmo, m_done;
   int       m_ticks, m_tx, m_guard, m_tmo_lim, m_quiet, m_count;
   logic [3:0] m_mode;

   always @(negedge ck or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_det = 0; m_full = 0; m_tag = 0; m_tmo = 0; m_done = 0;
         m_ticks = 0; m_tx = 0; m_guard = 0; m_tmo_lim = 0; m_quiet = 0; m_count = 0;
         m_mode = 4'd1;
      end else begin
         m_tag = 0; m_tmo = 0; m_done = 0;
         if (cmd_abort) begin
            m_busy = 0;
         end else if (!m_busy) begin
            if (cmd_start) begin
               m_tx = int'(tx_frames); m_guard = int'(guard_frames);
               m_tmo_lim = int'(rx_timeout); m_full = cmd_full_mod;
               m_busy = 1; m_det = 0; m_ticks = 0; m_count = 0; m_quiet = 0;
            end
         end else if (frame_tick) begin
            if (m_det) begin
               m_count = (m_count < 4095) ? m_count + 1 : 4095;
               m_quiet = (amp_in < amp_thresh) ? m_quiet + 1 : 0;
               if (m_quiet == 3) begin m_done = 1; m_busy = 0; end
            end else if (m_ticks >= m_tx + m_guard) begin
               if (amp_in >= amp_thresh) begin
                  m_tag = 1; m_det = 1; m_count = 1; m_quiet = 0;
               end else if (m_ticks - m_tx - m_guard + 1 >= m_tmo_lim) begin
                  m_tmo = 1; m_done = 1; m_busy = 0;
               end
            end
            m_ticks++;
         end
         if (!m_busy) m_mode = sniff_en ? 4'd7 : 4'd1;
         else if (m_ticks < m_tx) m_mode = m_full ? 4'd4 : 4'd5;
         else m_mode = 4'd1;
      end
   end

   always @(posedge ck) begin
      if (check_en) begin
         checkOutput("minor_mode", 16'(minor_mode), 16'(m_mode));
         checkOutput("busy", 16'(busy), 16'(m_busy));
         checkOutput("rx_active", 16'(rx_active), 16'(m_busy && (m_det || m_ticks >= m_tx + m_guard)));
         checkOutput("tag_detect", 16'(tag_detect), 16'(m_tag));
         checkOutput("timeout", 16'(timeout), 16'(m_tmo));
         checkOutput("done", 16'(done), 16'(m_done));
         checkOutput("rx_count", 16'(rx_count), 16'(m_count));
      end
   end

   task automatic applyStimulus(input logic start, input logic abort, input logic tick);
      cmd_start = start; cmd_abort = abort; frame_tick = tick;
      @(posedge ck); #1;
      cmd_start = 1'b0; cmd_abort = 1'b0; frame_tick = 1'b0;
   endtask

   task automatic frames(input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         for (int g = 0; g < gap; g++) applyStimulus(1'b0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      #1 rst_n = 1'b0;
      check_en = 1'b1;
      @(posedge ck); #1;
      checkOutput("reset_mode", 16'(minor_mode), 16'd1);
      checkOutput("reset_busy", 16'(busy), 16'd0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // idle mode follows sniff_en
      sniff_en = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_sniff", 16'(minor_mode), 16'd7);
      sniff_en = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("idle_rx", 16'(minor_mode), 16'd1);

      // reset in the middle of TX
      tx_frames = 12'd5; guard_frames = 8'd1; rx_timeout = 12'd3; cmd_full_mod = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      frames(2, 2);
      checkOutput("midtx_mode", 16'(minor_mode), 16'd4);
      rst_n = 1'b0;
      #1;
      checkOutput("rst_async_mode", 16'(minor_mode), 16'd1);
      checkOutput("rst_async_busy", 16'(busy), 16'd0);
      checkOutput("rst_async_done", 16'(done), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);

      // full modulation, timeout after 4 empty receive ticks
      tx_frames = 12'd3; guard_frames = 8'd2; rx_timeout = 12'd4; cmd_full_mod = 1'b1;
      amp_thresh = 14'd100; amp_in = 14'd0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("s2_mode_tx", 16'(minor_mode), 16'd4);
      checkOutput("s2_busy", 16'(busy), 16'd1);
      tx_frames = 12'd7; cmd_full_mod = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      frames(2, 2);
      checkOutput("s2_mode_tx2", 16'(minor_mode), 16'd4);
      frames(1, 2);
      checkOutput("s2_mode_guard", 16'(minor_mode), 16'd1);
      checkOutput("s2_guard_rx", 16'(rx_active), 16'd0);
      frames(2, 2);
      checkOutput("s2_rx_active", 16'(rx_active), 16'd1);
      frames(3, 2);
      checkOutput("s2_no_tmo_yet", 16'(timeout), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("s2_timeout", 16'(timeout), 16'd1);
      checkOutput("s2_done", 16'(done), 16'd1);
      checkOutput("s2_busy_low", 16'(busy), 16'd0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("s2_pulse_end", 16'(done), 16'd0);

      // shallow modulation, detect then 3 quiet frames
      tx_frames = 12'd1; guard_frames = 8'd0; rx_timeout = 12'd10; cmd_full_mod = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("s3_mode_tx", 16'(minor_mode), 16'd5);
      frames(1, 1);
      amp_in = 14'd100;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("s3_tag", 16'(tag_detect), 16'd1);
      checkOutput("s3_count1", 16'(rx_count), 16'd1);
      frames(5, 1);
      amp_in = 14'd0;
      frames(2, 1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("s3_done", 16'(done), 16'd1);
      checkOutput("s3_count9", 16'(rx_count), 16'd9);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // zero lengths: detection beats an immediate timeout; then abort+start in RX_DATA
      sniff_en = 1'b1;
      tx_frames = 12'd0; guard_frames = 8'd0; rx_timeout = 12'd0; amp_in = 14'd200;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("s4_rx_direct", 16'(rx_active), 16'd1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("s4_tag", 16'(tag_detect), 16'd1);
      checkOutput("s4_no_tmo", 16'(timeout), 16'd0);
      frames(2, 1);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("s4_abort_busy", 16'(busy), 16'd0);
      checkOutput("s4_abort_done", 16'(done), 16'd0);
      checkOutput("s4_abort_count", 16'(rx_count), 16'd3);
      checkOutput("s4_abort_mode", 16'(minor_mode), 16'd7);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("s4_start_dropped", 16'(busy), 16'd0);
      sniff_en = 1'b0;

      // rx_count saturation
      rx_timeout = 12'd10; amp_in = 14'd200;
      applyStimulus(1'b1, 1'b0, 1'b0);
      frames(5000, 1);
      checkOutput("s5_saturate", 16'(rx_count), 16'd4095);
      checkOutput("s5_busy", 16'(busy), 16'd1);
      amp_in = 14'd99;
      frames(3, 1);
      checkOutput("s5_final_count", 16'(rx_count), 16'd4095);
      checkOutput("s5_idle", 16'(busy), 16'd0);

      check_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      n_err++;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/hi_reader_seq.md
Name: hi_reader_seq

Overview:
- Exchange sequencer for the HF reader datapath.
- On one ARM command it steps the datapath's minor_mode through transmit (antenna modulation), a guard interval, and tag-response reception.
- During reception it judges tag presence from the per-frame correlation amplitude and reports detect, timeout or completion.
- Sits between the ARM command registers and the HF reader datapath. Its timebase is the datapath's 64-sample report boundary (frame_tick).

Parameters:
- MODE_RX_AMP, 4'd1, minor_mode code for receive-amplitude (carrier on, unmodulated).
- MODE_SEND_FULL, 4'd4, minor_mode code for full-modulation transmit.
- MODE_SEND_SHALLOW, 4'd5, minor_mode code for shallow-modulation transmit.
- MODE_SNIFF_AMP, 4'd7, minor_mode code for sniff-amplitude (all drivers off).
- QUIET_FRAMES, 3, consecutive below-threshold frames that end reception.

Ports:
- ck_1356meg  in  1  13.56 MHz clock; all logic on negedge, matching the datapath.
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at each datapath report boundary (corr_i_cnt==0).
- cmd_start  in  1  pulse; begin exchange.
- cmd_abort  in  1  pulse; abandon exchange.
- cmd_full_mod  in  1  1=full mod, 0=shallow; sampled at start.
- sniff_en  in  1  idle mode select: 1=MODE_SNIFF_AMP, 0=MODE_RX_AMP.
- tx_frames  in  12  transmit length in frames; sampled at start.
- guard_frames  in  8  guard length in frames; sampled at start.
- rx_timeout  in  12  frames to wait for a tag; sampled at start.
- amp_in  in  14  current correlation amplitude, unsigned.
- amp_thresh  in  14  tag-present threshold, unsigned.
- minor_mode  out  4  mode driven to the datapath (registered).
- busy  out  1  high in every state except IDLE.
- rx_active  out  1  high in RX_WAIT and RX_DATA.
- tag_detect  out  1  one-cycle pulse on tag detection.
- timeout  out  1  one-cycle pulse on no-response.
- done  out  1  one-cycle pulse at normal completion or timeout.
- rx_count  out  12  frames counted in RX_DATA; holds until the next start.

Behaviour:
- Reset (async assert): state=IDLE, minor_mode=MODE_RX_AMP, all pulses 0, busy=0, rx_active=0, rx_count=0, counters 0. Release is synchronous to negedge.
- IDLE: minor_mode follows sniff_en with 1-cycle latency. cmd_start latches tx_frames/guard_frames/rx_timeout/cmd_full_mod, clears rx_count, enters TX next edge.
- TX: minor_mode = cmd_full_mod ? MODE_SEND_FULL : MODE_SEND_SHALLOW from the cycle after start. The down-counter decrements on frame_tick; the tick that reaches 0 moves to GUARD. If tx_frames=0 at start, go directly IDLE->GUARD.
- GUARD: minor_mode=MODE_RX_AMP; amp_in ignored. Lasts guard_frames ticks; if 0, go directly to RX_WAIT.
- RX_WAIT: minor_mode=MODE_RX_AMP; wait counter starts at 0. On each frame_tick:
  - amp_in>=amp_thresh: pulse tag_detect, go to RX_DATA, rx_count=1.
  - otherwise: increment wait counter; when counter==rx_timeout, pulse timeout and done together, go to IDLE.
  - Detection and timeout on the same tick: detection wins.
  - rx_timeout=0: timeout on the first tick without detection.
- RX_DATA: on each frame_tick, rx_count+1, saturating at 4095.
  - amp_in<amp_thresh increments a quiet counter; amp_in>=amp_thresh clears it.
  - The tick where quiet reaches QUIET_FRAMES pulses done and returns to IDLE; that tick still counts in rx_count.
- Comparisons are unsigned 14-bit; equality with the threshold means present.
- cmd_abort: from any state, go to IDLE on the next edge with no done/timeout pulse. rx_count keeps its current value. Abort and start in the same cycle: abort wins and start is dropped.
- cmd_start while busy is ignored. Mode inputs changed mid-exchange have no effect until the next start; sniff_en is read only in IDLE.
- frame_tick asserted in the cycle of a state change is consumed by the old state only.
- No output combinationally depends on any input.

Test Plan:
- Reset mid-TX (tx_frames=5, assert rst_n low after 2 ticks) -> immediate minor_mode=4'd1, busy=0, no pulses.
- start, full_mod=1, tx=3, guard=2, timeout=4, amp_in=0 -> minor_mode=4 for 3 ticks, then 1. timeout+done pulse on the 4th RX_WAIT tick (tick 9 after start); busy falls the next edge.
- start, shallow, tx=1, guard=0, amp_thresh=100, amp_in=100 from the first RX tick for 6 ticks then 0 -> minor_mode=5, tag_detect on RX tick 1, done after 3 quiet ticks, rx_count=9.
- tx=0, guard=0, rx_timeout=0, amp_in=200, thresh=100 -> first tick detects (detection beats timeout), no timeout pulse.
- Abort during RX_DATA with simultaneous cmd_start -> IDLE next edge, no done, rx_count retained, minor_mode follows sniff_en (sniff_en=1 -> 4'd7).
- amp_in held above threshold for 5000 ticks -> rx_count saturates at 4095, no wrap.
